alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised ALU execute stage for the MIPS datapath. It combines funct/aluop decode with execution, and adds a registered result and an iterative multiply/divide engine with HI/LO registers. It sits between register read and writeback. A valid/ready handshake stalls issue while a multiply or divide is in flight.

## Interface
- `WIDTH`, default 32: datapath width; must be at least 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an operation is presented.
- `in_ready`  out  1  the unit can accept an operation; equals `!busy` (combinational).
- `aluop`  in  2  00 = add (load/store), 01 = sub (branch), 10 = decode `funct`, 11 = illegal.
- `funct`  in  6  R-type function field.
- `op_a`, `op_b`  in  `WIDTH` each  operands; `op_a` = rs, `op_b` = rt/imm.
- `out_valid`  out  1  one-cycle pulse; result and flags are valid.
- `result`  out  `WIDTH`  registered result.
- `zero`  out  1  `result == 0`.
- `ovf`  out  1  signed overflow on add/sub only.
- `illegal`  out  1  undefined aluop/funct.
- `busy`  out  1  multiply/divide in progress.

## Operation
- Accept occurs when `in_valid && in_ready` at a rising edge.
- Funct codes:
  - Arithmetic/logic: add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111.
  - Compare: slt 101010 (signed), sltu 101011 (unsigned); both produce 0 or 1 zero-extended.
  - HI/LO read: mfhi 010000, mflo 010010.
  - Multiply/divide: mult 011000, multu 011001, div 011010, divu 011011.
- Arithmetic is `WIDTH` bits and wraps modulo 2^`WIDTH`.
  - `ovf` = signed overflow for add/sub and aluop 00/01.
  - `ovf` = 0 for all other operations.
- Undefined funct, or aluop 11: `illegal` = 1, `result` = 0, no HI/LO change.
- Multiply: the full 2·`WIDTH` product goes to {HI,LO}.
  - Engine is shift-add on operand magnitudes; sign is corrected in the DONE state.
- Divide: quotient goes to LO, remainder to HI.
  - Engine is restoring division on magnitudes.
  - Quotient is truncated toward zero; remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = `op_a`; no trap.
  - Signed MIN / −1: LO = MIN, HI = 0.
- For mult/div, `result` shows the new LO.
- State machine:
  - IDLE → ITER on accepting a mult/div; the iteration counter (`$clog2(WIDTH+1)` bits) is loaded with `WIDTH`.
  - ITER → DONE when the counter reaches 0.
  - DONE → IDLE unconditionally. DONE writes HI/LO and pulses `out_valid`.
- Single-cycle operations never leave IDLE.

## Timing
- Reset state:
  - State IDLE; HI = LO = 0.
  - `out_valid`, `result`, `zero`, `ovf`, `illegal`, `busy` all 0.
  - `in_ready` = 1.
- Single-cycle operations: accepted at edge N, outputs valid with `out_valid` = 1 in the cycle after edge N. Full throughput: one operation per cycle.
- Mult/div:
  - Accepted at edge N; `busy` = 1 from edge N through edge N+`WIDTH`.
  - `out_valid` pulses in the cycle after edge N+`WIDTH`+1, with `in_ready` = 1 in that same cycle.
  - Latency is `WIDTH`+1 cycles.
- While busy, `in_valid` is ignored; mfhi/mflo cannot issue until the write completes.
- `out_valid` is never held; there is no output backpressure.
- `result` and the flags hold their last values between pulses.
- Reset mid-operation aborts immediately: HI/LO are cleared and no `out_valid` pulse is produced.

## Configuration
- `ALU_EXEC_DIV_EN` defined: div/divu are implemented as above.
- `ALU_EXEC_DIV_EN` undefined:
  - div/divu decode as illegal: single-cycle, `illegal` = 1, HI/LO unchanged.
  - The divider datapath is not synthesised; multiply is unaffected.

## Structure
- Package `alu_exec_pkg` holds:
  - aluop localparams and funct localparams;
  - internal op enum (ADD…DIVU, ILLEGAL);
  - state enum {IDLE, ITER, DONE}.
- Sub-module `alu_muldiv_seq`:
  - contains the iterative engine (counter, shift-add/restoring datapath, sign fix-up);
  - takes start, signed, is_div, a, b; returns done, hi, lo.
- The top level holds decode, the single-cycle ALU, HI/LO and output registers.

## Test plan
- sub: `aluop` = 10, `funct` = 100010, a = 5, b = 7 → next cycle `out_valid` = 1, `result` = 0xFFFFFFFE, `zero` = 0, `ovf` = 0.
- add vs addu: add with a = 0x7FFFFFFF, b = 1 → `result` = 0x80000000, `ovf` = 1. Same operands with addu → `ovf` = 0. Then sub with a = b = 3 → `zero` = 1.
- mult: a = 0xFFFFFFFD, b = 7 → `in_ready` low 33 cycles, `out_valid` at +33, `result` = 0xFFFFFFEB. Then mfhi → 0xFFFFFFFF, mflo → 0xFFFFFFEB.
- divide (`ALU_EXEC_DIV_EN`):
  - div a = −7, b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu a = 9, b = 0 → LO = 0xFFFFFFFF, HI = 9.
  - Without the macro, div → `illegal` = 1 after 1 cycle.
- reset mid-operation: assert `rst_n` low 10 cycles into multu → no `out_valid`, `in_ready` = 1; after release, mfhi → 0.
- illegal decode: `funct` = 111111 → `illegal` = 1, `result` = 0. `aluop` = 11 → `illegal` = 1. A mult issued during busy with `in_valid` = 1 is not accepted.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared decode constants, internal op encoding and sequencer states for alu_exec_unit.
// Build option: ALU_EXEC_DIV_EN enables the div/divu datapath.
package alu_exec_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_ILLEGAL
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_e;

  function automatic logic is_muldiv(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide engine: shift-add / restoring division on magnitudes, sign fix in DONE.
// Build option: ALU_EXEC_DIV_EN includes the restoring-division datapath.
module alu_muldiv_seq
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opd;
  logic neg_q, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0] msum;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

  // acc_lo holds the multiplier and shifts right as product bits arrive in acc_hi
  assign msum = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_lo[0]}} & opd};

`ifdef ALU_EXEC_DIV_EN
  logic div_q, neg_r, b_zero;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0] rsh, rdif;
  logic rge;
  assign rsh  = {acc_hi, acc_lo[WIDTH-1]};
  assign rdif = rsh - {1'b0, opd};
  assign rge  = (rsh >= {1'b0, opd});
`else
  logic unused_div;
  assign unused_div = is_div;
`endif

  // Leave ITER on the edge that takes the counter to zero
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ITER;
      ST_ITER: if (cnt == CW'(1)) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
      neg_q  <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      div_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_q    <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        cnt    <= CNT_INIT;
        acc_hi <= '0;
        acc_lo <= a_mag;
        opd    <= b_mag;
        neg_q  <= a_neg ^ b_neg;
`ifdef ALU_EXEC_DIV_EN
        div_q  <= is_div;
        neg_r  <= a_neg;
        b_zero <= (b == '0);
        a_q    <= a;
`endif
      end else if (state == ST_ITER) begin
        cnt <= cnt - CW'(1);
`ifdef ALU_EXEC_DIV_EN
        if (div_q) begin
          acc_hi <= rge ? rdif[WIDTH-1:0] : rsh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], rge};
        end else
`endif
        begin
          acc_hi <= msum[WIDTH:1];
          acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
        end
      end
    end
  end

  assign prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

  always_comb begin
    hi = prod[2*WIDTH-1:WIDTH];
    lo = prod[WIDTH-1:0];
`ifdef ALU_EXEC_DIV_EN
    if (div_q) begin
      if (b_zero) begin
        lo = '1;
        hi = a_q;
      end else begin
        lo = neg_q ? -acc_lo : acc_lo;
        hi = neg_r ? -acc_hi : acc_hi;
      end
    end
`endif
  end

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS ALU execute stage: decode, single-cycle ALU, HI/LO and registered outputs.
// Build option: ALU_EXEC_DIV_EN enables div/divu (otherwise they decode as illegal).
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             busy
);
  op_e op;
  logic accept, is_md, md_done;
  logic [WIDTH-1:0] hi_q, lo_q, md_hi, md_lo, sum, dif, alu_res;
  logic add_ovf, sub_ovf, alu_ovf;

  always_comb begin
    op = OP_ILLEGAL;
    case (aluop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   op = OP_ADD;
          F_ADDU:  op = OP_ADDU;
          F_SUB:   op = OP_SUB;
          F_SUBU:  op = OP_SUBU;
          F_AND:   op = OP_AND;
          F_OR:    op = OP_OR;
          F_XOR:   op = OP_XOR;
          F_NOR:   op = OP_NOR;
          F_SLT:   op = OP_SLT;
          F_SLTU:  op = OP_SLTU;
          F_MFHI:  op = OP_MFHI;
          F_MFLO:  op = OP_MFLO;
          F_MULT:  op = OP_MULT;
          F_MULTU: op = OP_MULTU;
`ifdef ALU_EXEC_DIV_EN
          F_DIV:   op = OP_DIV;
          F_DIVU:  op = OP_DIVU;
`endif
          default: op = OP_ILLEGAL;
        endcase
      end
      default: op = OP_ILLEGAL;
    endcase
  end

  assign sum     = op_a + op_b;
  assign dif     = op_a - op_b;
  assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = sum; alu_ovf = add_ovf; end
      OP_ADDU: alu_res = sum;
      OP_SUB:  begin alu_res = dif; alu_ovf = sub_ovf; end
      OP_SUBU: alu_res = dif;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign is_md    = is_muldiv(op);
  assign in_ready = ~busy;
  assign accept   = in_valid & ~busy;

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept & is_md),
    .sgn    ((op == OP_MULT) || (op == OP_DIV)),
    .is_div ((op == OP_DIV) || (op == OP_DIVU)),
    .a      (op_a),
    .b      (op_b),
    .busy   (busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // Engine completion and single-cycle accept are mutually exclusive: DONE keeps busy high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (md_done) begin
        hi_q      <= md_hi;
        lo_q      <= md_lo;
        out_valid <= 1'b1;
        result    <= md_lo;
        zero      <= (md_lo == '0);
        ovf       <= 1'b0;
        illegal   <= 1'b0;
      end else if (accept && !is_md) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        zero      <= (alu_res == '0);
        ovf       <= alu_ovf;
        illegal   <= (op == OP_ILLEGAL);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, hand-written mult/div/reset sequences, random vs model.
module tb_alu_exec_unit;
  localparam int W = 32;
  localparam int MD_LAT = W + 2; // negedges from the accepting edge to the out_valid cycle
  localparam longint SMAX = (longint'(1) <<< 31) - 1;
  localparam longint SMIN = -(longint'(1) <<< 31);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] aluop = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic out_valid, zero, ovf, illegal, busy;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .result(result), .zero(zero), .ovf(ovf),
    .illegal(illegal), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi = '0, mlo = '0;

  typedef struct {
    logic [1:0] aop; logic [5:0] f; logic [31:0] a, b, r; logic z, ov, il;
  } vec_t;
  vec_t tbl[$];

  logic [5:0] flist[18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                            6'h2b, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h3f, 6'h00};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] aop, input logic [5:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] r, input logic z,
                              input logic ov, input logic il);
    vec_t v;
    v.aop = aop; v.f = f; v.a = a; v.b = b; v.r = r; v.z = z; v.ov = ov; v.il = il;
    return v;
  endfunction

  // Reference model: plain 64-bit arithmetic; keeps its own HI/LO
  task automatic model(input logic [1:0] aop, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r, output logic ov,
                       output logic il, output logic md);
    longint sa, sb, s;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b);
    r = '0; ov = 1'b0; il = 1'b0; md = 1'b0; s = 0; p = '0;
    case (aop)
      2'b00: begin s = sa + sb; r = a + b; ov = (s > SMAX) || (s < SMIN); end
      2'b01: begin s = sa - sb; r = a - b; ov = (s > SMAX) || (s < SMIN); end
      2'b11: il = 1'b1;
      default: case (f)
        6'h20: begin s = sa + sb; r = a + b; ov = (s > SMAX) || (s < SMIN); end
        6'h21: r = a + b;
        6'h22: begin s = sa - sb; r = a - b; ov = (s > SMAX) || (s < SMIN); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h2b: r = (a < b) ? 32'd1 : 32'd0;
        6'h10: r = mhi;
        6'h12: r = mlo;
        6'h18: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; r = mlo; md = 1'b1; end
        6'h19: begin p = {32'b0, a} * {32'b0, b}; mhi = p[63:32]; mlo = p[31:0]; r = mlo; md = 1'b1; end
`ifdef ALU_EXEC_DIV_EN
        6'h1a: begin
          md = 1'b1;
          if (b == 0) begin mlo = '1; mhi = a; end
          else begin p = sa / sb; mlo = p[31:0]; p = sa % sb; mhi = p[31:0]; end
          r = mlo;
        end
        6'h1b: begin
          md = 1'b1;
          if (b == 0) begin mlo = '1; mhi = a; end
          else begin mlo = a / b; mhi = a % b; end
          r = mlo;
        end
`endif
        default: il = 1'b1;
      endcase
    endcase
  endtask

  task automatic do_op(input logic [1:0] aop, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r, output logic z,
                       output logic ov, output logic il, output int lat);
    lat = -1; r = '0; z = 1'b0; ov = 1'b0; il = 1'b0;
    @(negedge clk);
    aluop = aop; funct = f; op_a = a; op_b = b; in_valid = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k; r = result; z = zero; ov = ovf; il = illegal;
        break;
      end
    end
  endtask

  task automatic rand_op(input logic [1:0] aop, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
    logic [31:0] er, r;
    logic eov, eil, emd, z, ov, il;
    int lat;
    model(aop, f, a, b, er, eov, eil, emd);
    do_op(aop, f, a, b, r, z, ov, il, lat);
    chk({tag, ".lat"}, lat, emd ? MD_LAT : 1);
    chk({tag, ".result"}, r, er);
    chk({tag, ".zero"}, z, er == 0);
    chk({tag, ".ovf"}, ov, eov);
    chk({tag, ".illegal"}, il, eil);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] r, er;
    logic z, ov, il, eov, eil, emd, rdy;
    int lat, low, ovk, cnt;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.flags", {zero, ovf, illegal, busy}, 4'b0000);
    chk("rst.in_ready", in_ready, 1);

    // Single-cycle vectors, issued back to back
    tbl.push_back(mk(2'b10, 6'h22, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0));
    tbl.push_back(mk(2'b10, 6'h20, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1, 0));
    tbl.push_back(mk(2'b10, 6'h21, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 0, 0));
    tbl.push_back(mk(2'b10, 6'h22, 32'd3, 32'd3, 32'h0, 1, 0, 0));
    tbl.push_back(mk(2'b10, 6'h23, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 0));
    tbl.push_back(mk(2'b10, 6'h24, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 0, 0, 0));
    tbl.push_back(mk(2'b10, 6'h25, 32'hF0F00000, 32'h0000FF0F, 32'hF0F0FF0F, 0, 0, 0));
    tbl.push_back(mk(2'b10, 6'h26, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 0, 0, 0));
    tbl.push_back(mk(2'b10, 6'h27, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0, 1, 0, 0));
    tbl.push_back(mk(2'b10, 6'h2a, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0));
    tbl.push_back(mk(2'b10, 6'h2b, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 0));
    tbl.push_back(mk(2'b00, 6'h00, 32'h80000000, 32'h80000000, 32'h0, 1, 1, 0));
    tbl.push_back(mk(2'b01, 6'h00, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 0));
    tbl.push_back(mk(2'b01, 6'h3f, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0));
    tbl.push_back(mk(2'b10, 6'h3f, 32'd11, 32'd12, 32'h0, 1, 0, 1));
    tbl.push_back(mk(2'b11, 6'h20, 32'd1, 32'd2, 32'h0, 1, 0, 1));
    tbl.push_back(mk(2'b10, 6'h10, 32'd4, 32'd4, 32'h0, 1, 0, 0));
`ifndef ALU_EXEC_DIV_EN
    tbl.push_back(mk(2'b10, 6'h1a, 32'd9, 32'd2, 32'h0, 1, 0, 1));
    tbl.push_back(mk(2'b10, 6'h12, 32'd0, 32'd0, 32'h0, 1, 0, 0));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      aluop = tbl[i].aop; funct = tbl[i].f; op_a = tbl[i].a; op_b = tbl[i].b; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d.out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d.result", i), result, tbl[i].r);
      chk($sformatf("vec%0d.zero", i), zero, tbl[i].z);
      chk($sformatf("vec%0d.ovf", i), ovf, tbl[i].ov);
      chk($sformatf("vec%0d.illegal", i), illegal, tbl[i].il);
      chk($sformatf("vec%0d.busy", i), busy, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle.out_valid", out_valid, 0);
    chk("idle.result_hold", result, tbl[tbl.size()-1].r);

    // mult with a second mult held valid while busy
    aluop = 2'b10; funct = 6'h18; op_a = 32'hFFFFFFFD; op_b = 32'd7; in_valid = 1'b1;
    low = 0; ovk = -1; r = '0; rdy = 1'b0;
    for (int k = 1; k <= 100 && ovk < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin op_a = 32'h1234; op_b = 32'h5678; end
      if (!in_ready) low++;
      if (out_valid) begin ovk = k; r = result; rdy = in_ready; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    chk("mult.ready_low_cycles", low, W + 1);
    chk("mult.out_valid_cycle", ovk, MD_LAT);
    chk("mult.result", r, 32'hFFFFFFEB);
    chk("mult.in_ready_at_done", rdy, 1);
    @(negedge clk);
    chk("mult.held_not_accepted", {busy, out_valid}, 2'b00);
    model(2'b10, 6'h18, 32'hFFFFFFFD, 32'd7, er, eov, eil, emd);
    do_op(2'b10, 6'h10, 0, 0, r, z, ov, il, lat);
    chk("mfhi.result", r, 32'hFFFFFFFF);
    do_op(2'b10, 6'h12, 0, 0, r, z, ov, il, lat);
    chk("mflo.result", r, 32'hFFFFFFEB);

`ifdef ALU_EXEC_DIV_EN
    model(2'b10, 6'h1a, 32'hFFFFFFF9, 32'd2, er, eov, eil, emd);
    do_op(2'b10, 6'h1a, 32'hFFFFFFF9, 32'd2, r, z, ov, il, lat);
    chk("div.lat", lat, MD_LAT);
    chk("div.lo", r, 32'hFFFFFFFD);
    do_op(2'b10, 6'h10, 0, 0, r, z, ov, il, lat);
    chk("div.hi", r, 32'hFFFFFFFF);
    model(2'b10, 6'h1b, 32'd9, 32'd0, er, eov, eil, emd);
    do_op(2'b10, 6'h1b, 32'd9, 32'd0, r, z, ov, il, lat);
    chk("divu0.lo", r, 32'hFFFFFFFF);
    do_op(2'b10, 6'h10, 0, 0, r, z, ov, il, lat);
    chk("divu0.hi", r, 32'd9);
    rand_op(2'b10, 6'h1a, 32'h80000000, 32'hFFFFFFFF, "div_min");
    rand_op(2'b10, 6'h10, 0, 0, "div_min.hi");
`else
    do_op(2'b10, 6'h1a, 32'hFFFFFFF9, 32'd2, r, z, ov, il, lat);
    chk("nodiv.lat", lat, 1);
    chk("nodiv.illegal", il, 1);
    do_op(2'b10, 6'h10, 0, 0, r, z, ov, il, lat);
    chk("nodiv.hi_kept", r, 32'hFFFFFFFF);
`endif

    // Randomised ops against the model
    for (int n = 0; n < 60; n++) begin
      logic [1:0] aop;
      logic [5:0] f;
      case ($urandom_range(0, 19))
        0: aop = 2'b00;
        1: aop = 2'b01;
        2: aop = 2'b11;
        default: aop = 2'b10;
      endcase
      f = flist[$urandom_range(0, 17)];
      rand_op(aop, f, rnd_val(), rnd_val(), $sformatf("rnd%0d_%0h_%0h", n, aop, f));
    end

    // Reset part-way through a multu
    @(negedge clk);
    aluop = 2'b10; funct = 6'h19; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid.out_valid", out_valid, 0);
    chk("rstmid.in_ready", in_ready, 1);
    chk("rstmid.busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("rstmid.no_pulse", cnt, 0);
    mhi = '0; mlo = '0;
    do_op(2'b10, 6'h10, 0, 0, r, z, ov, il, lat);
    chk("rstmid.mfhi", r, 0);
    rand_op(2'b10, 6'h12, 0, 0, "rstmid.mflo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
